// File: rtl/inst_issuer.sv
// Instruction issuer: an 8-deep instruction FIFO feeding a processor one word at a time,
// stepping a 2-bit timestep until the controller signals completion with Clr.
module inst_issuer (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [9:0] wr_data,
    input  logic       run,
    input  logic       Clr,
    output logic [9:0] INST,
    output logic [1:0] T,
    output logic       busy,
    output logic       full,
    output logic       empty,
    output logic [3:0] count,
    output logic [7:0] retired,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        ERROR = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  mem_q [8];
    logic [2:0]  rd_ptr_q, wr_ptr_q;
    logic [3:0]  count_q, count_d;
    logic [9:0]  inst_q, inst_d;
    logic [1:0]  t_q, t_d;
    logic [7:0]  retired_q, retired_d;
    logic        err_q, err_d;
    logic        busy_q;
    logic        push, pop;
    logic [9:0]  head;

    assign full  = (count_q == 4'd8);
    assign empty = (count_q == 4'd0);
    assign head  = mem_q[rd_ptr_q];

    // A push while full is dropped even if a pop frees a slot on the same edge.
    assign push  = wr_en && !full;

    always_comb begin
        state_d   = state_q;
        inst_d    = inst_q;
        t_d       = t_q;
        retired_d = retired_q;
        err_d     = err_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                t_d = 2'd0;
                if (run && !empty && !err_q) begin
                    state_d = EXEC;
                    inst_d  = head;
                    pop     = 1'b1;
                end
            end
            EXEC: begin
                if (Clr) begin
                    t_d       = 2'd0;
                    retired_d = retired_q + 8'd1;
                    if (run && !empty) begin
                        inst_d = head;
                        pop    = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (t_q == 2'd3) begin
                    err_d   = 1'b1;
                    t_d     = 2'd0;
                    state_d = ERROR;
                end else begin
                    t_d = t_q + 2'd1;
                end
            end
            ERROR: begin
                t_d = 2'd0;
            end
            default: begin
                state_d = IDLE;
                t_d     = 2'd0;
            end
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 4'd1;
        end else if (pop && !push) begin
            count_d = count_q - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rd_ptr_q  <= 3'd0;
            wr_ptr_q  <= 3'd0;
            count_q   <= 4'd0;
            inst_q    <= 10'h000;
            t_q       <= 2'd0;
            retired_q <= 8'd0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            inst_q    <= inst_d;
            t_q       <= t_d;
            retired_q <= retired_d;
            err_q     <= err_d;
            busy_q    <= (state_d == EXEC);
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 3'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 3'd1;
            end
        end
    end

    // Storage needs no reset: entries are only read once the pointers say they were written.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign INST    = inst_q;
    assign T       = t_q;
    assign busy    = busy_q;
    assign count   = count_q;
    assign retired = retired_q;
    assign err     = err_q;

endmodule

// File: tb/tb_inst_issuer.sv
// Bench for inst_issuer: a queue-based reference model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_inst_issuer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic [9:0] wr_data = 10'h000;
    logic       run = 1'b0;
    logic       Clr = 1'b0;
    logic [9:0] INST;
    logic [1:0] T;
    logic       busy;
    logic       full;
    logic       empty;
    logic [3:0] count;
    logic [7:0] retired;
    logic       err;

    int checks = 0;
    int errors = 0;
    bit cmpEn = 1'b0;
    bit seen9 = 1'b0;

    // Reference model state: queue contents, issued word, timestep, phase flags
    int mq[$];
    int mInst = 0;
    int mT = 0;
    int mRetired = 0;
    bit mExec = 1'b0;
    bit mErr = 1'b0;
    bit mAccept = 1'b0;

    inst_issuer dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .run     (run),
        .Clr     (Clr),
        .INST    (INST),
        .T       (T),
        .busy    (busy),
        .full    (full),
        .empty   (empty),
        .count   (count),
        .retired (retired),
        .err     (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            mInst = 0;
            mT = 0;
            mRetired = 0;
            mExec = 1'b0;
            mErr = 1'b0;
        end else begin
            mAccept = wr_en && (mq.size() < 8);
            if (mErr) begin
                mT = 0;
            end else if (!mExec) begin
                if (run && mq.size() > 0) begin
                    mInst = mq.pop_front();
                    mT = 0;
                    mExec = 1'b1;
                end
            end else if (Clr) begin
                mRetired = (mRetired + 1) % 256;
                mT = 0;
                if (run && mq.size() > 0) mInst = mq.pop_front();
                else mExec = 1'b0;
            end else if (mT == 3) begin
                mErr = 1'b1;
                mT = 0;
                mExec = 1'b0;
            end else begin
                mT = mT + 1;
            end
            if (mAccept) mq.push_back(int'(wr_data));
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmpEn && !rst) begin
            if (INST == 10'h009) seen9 = 1'b1;
            checkOutput("cyc_INST", int'(INST), mInst);
            checkOutput("cyc_T", int'(T), mT);
            checkOutput("cyc_busy", int'(busy), int'(mExec));
            checkOutput("cyc_full", int'(full), int'(mq.size() == 8));
            checkOutput("cyc_empty", int'(empty), int'(mq.size() == 0));
            checkOutput("cyc_count", int'(count), mq.size());
            checkOutput("cyc_retired", int'(retired), mRetired);
            checkOutput("cyc_err", int'(err), int'(mErr));
        end
    end

    task automatic applyStimulus(input logic we, input logic [9:0] d, input logic r, input logic c);
        wr_en = we;
        wr_data = d;
        run = r;
        Clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        wr_en = 1'b0;
        run = 1'b0;
        Clr = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    logic [9:0] s2Words [3];
    logic [9:0] dropWord;

    initial begin
        s2Words[0] = 10'h102;
        s2Words[1] = 10'h213;
        s2Words[2] = 10'h2A0;
        dropWord = 10'h009;

        #2 rst = 1'b1;
        #10 rst = 1'b0;
        @(posedge clk);
        #1;
        cmpEn = 1'b1;
        checkOutput("rst_INST", int'(INST), 'h000);
        checkOutput("rst_count", int'(count), 0);
        checkOutput("rst_empty", int'(empty), 1);
        checkOutput("rst_full", int'(full), 0);

        // Scenario 1: queue three words without running
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, s2Words[i], 1'b0, 1'b0);
        checkOutput("s1_count", int'(count), 3);
        checkOutput("s1_busy", int'(busy), 0);
        checkOutput("s1_INST", int'(INST), 'h000);
        checkOutput("s1_T", int'(T), 0);
        checkOutput("s1_model_count", mq.size(), 3);

        // Scenario 2: back-to-back issue with Clr at T=2
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b0, 10'h000, 1'b1, (i > 0) && (i % 3 == 0));
            checkOutput("s2_T", int'(T), i % 3);
            checkOutput("s2_INST", int'(INST), int'(s2Words[i / 3]));
            checkOutput("s2_busy", int'(busy), 1);
        end
        applyStimulus(1'b0, 10'h000, 1'b1, 1'b1);
        checkOutput("s2_retired", int'(retired), 3);
        checkOutput("s2_empty", int'(empty), 1);
        checkOutput("s2_busy_end", int'(busy), 0);
        checkOutput("s2_INST_hold", int'(INST), 'h2A0);
        checkOutput("s2_model_retired", mRetired, 3);
        applyStimulus(1'b0, 10'h000, 1'b0, 1'b0);

        // Scenario 3 + 6: overfill, then push into a full queue on the popping edge
        doReset();
        seen9 = 1'b0;
        for (int k = 1; k <= 8; k++) applyStimulus(1'b1, 10'(k), 1'b0, 1'b0);
        checkOutput("s3_full", int'(full), 1);
        checkOutput("s3_count8", int'(count), 8);
        applyStimulus(1'b1, dropWord, 1'b0, 1'b0);
        checkOutput("s3_count_drop", int'(count), 8);
        applyStimulus(1'b1, dropWord, 1'b1, 1'b0);
        checkOutput("s6_count7", int'(count), 7);
        checkOutput("s6_INST1", int'(INST), 'h001);
        checkOutput("s6_full0", int'(full), 0);
        for (int k = 0; k < 10; k++) applyStimulus(1'b0, 10'h000, 1'b1, 1'b1);
        checkOutput("s3_retired", int'(retired), 8);
        checkOutput("s3_INST_last", int'(INST), 'h008);
        checkOutput("s3_empty", int'(empty), 1);
        checkOutput("s3_no9", int'(seen9), 0);
        applyStimulus(1'b0, 10'h000, 1'b0, 1'b0);

        // Scenario 4: missing Clr leads to sticky error
        doReset();
        applyStimulus(1'b1, 10'h055, 1'b0, 1'b0);
        applyStimulus(1'b1, 10'h066, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 10'h000, 1'b1, 1'b0);
            checkOutput("s4_T", int'(T), i);
        end
        applyStimulus(1'b0, 10'h000, 1'b1, 1'b0);
        checkOutput("s4_err", int'(err), 1);
        checkOutput("s4_T0", int'(T), 0);
        checkOutput("s4_busy", int'(busy), 0);
        checkOutput("s4_retired", int'(retired), 0);
        applyStimulus(1'b0, 10'h000, 1'b1, 1'b1);
        checkOutput("s4_clr_ignored", int'(retired), 0);
        applyStimulus(1'b1, 10'h077, 1'b1, 1'b0);
        applyStimulus(1'b0, 10'h000, 1'b1, 1'b0);
        applyStimulus(1'b0, 10'h000, 1'b1, 1'b0);
        checkOutput("s4_count", int'(count), 2);
        checkOutput("s4_INST_hold", int'(INST), 'h055);
        checkOutput("s4_model_err", int'(mErr), 1);

        // Scenario 5: asynchronous reset mid-instruction
        doReset();
        for (int k = 0; k < 5; k++) applyStimulus(1'b1, 10'h1A0 + 10'(k), 1'b0, 1'b0);
        applyStimulus(1'b0, 10'h000, 1'b1, 1'b0);
        applyStimulus(1'b0, 10'h000, 1'b1, 1'b0);
        checkOutput("s5_pre_T", int'(T), 1);
        checkOutput("s5_pre_count", int'(count), 4);
        #2 rst = 1'b1;
        #1;
        checkOutput("s5_INST", int'(INST), 'h000);
        checkOutput("s5_T", int'(T), 0);
        checkOutput("s5_busy", int'(busy), 0);
        checkOutput("s5_count", int'(count), 0);
        checkOutput("s5_empty", int'(empty), 1);
        checkOutput("s5_err", int'(err), 0);
        wr_en = 1'b1;
        wr_data = 10'h3FF;
        run = 1'b1;
        Clr = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("s5_ignore_count", int'(count), 0);
        checkOutput("s5_ignore_busy", int'(busy), 0);
        wr_en = 1'b0;
        run = 1'b0;
        Clr = 1'b0;
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        // Scenario 6 (cont.): simultaneous push and pop at count 3
        doReset();
        applyStimulus(1'b1, 10'h301, 1'b0, 1'b0);
        applyStimulus(1'b1, 10'h302, 1'b0, 1'b0);
        applyStimulus(1'b1, 10'h303, 1'b0, 1'b0);
        applyStimulus(1'b1, 10'h304, 1'b1, 1'b0);
        checkOutput("s6b_count", int'(count), 3);
        checkOutput("s6b_INST0", int'(INST), 'h301);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 10'h000, 1'b1, 1'b1);
            checkOutput("s6b_order", int'(INST), 'h302 + k);
        end
        applyStimulus(1'b0, 10'h000, 1'b1, 1'b1);
        checkOutput("s6b_retired", int'(retired), 4);
        checkOutput("s6b_busy", int'(busy), 0);
        applyStimulus(1'b0, 10'h000, 1'b0, 1'b0);

        cmpEn = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_issuer.md
INST_ISSUER -- requirements
Module: inst_issuer

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high.
REQ-002 SHALL expose ports (name  direction  width  meaning):
- clk  in  1  rising-edge system clock
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  push wr_data into the instruction queue
- wr_data  in  10  instruction word to enqueue (same 10-bit ISA the controller decodes)
- run  in  1  permit issuing queued instructions
- Clr  in  1  end-of-instruction pulse from the controller
- INST  out  10  instruction currently presented to the processor
- T  out  2  current timestep fed to the controller
- busy  out  1  an instruction is executing
- full  out  1  queue holds 8 entries
- empty  out  1  queue holds 0 entries
- count  out  4  queue occupancy, 0..8
- retired  out  8  instructions completed, modulo 256
- err  out  1  sticky timeout flag

Function
REQ-003 SHALL hold queued instructions in an 8-entry x 10-bit FIFO, in first-in first-out order.
REQ-004 Push rule: a push SHALL occur on a rising clk edge when wr_en=1 and full=0.
REQ-005 Push when full: wr_en=1 with full=1 SHALL be dropped, even if a pop occurs in the same cycle.
REQ-006 Simultaneous push and pop when not full SHALL leave count unchanged and keep FIFO order.
REQ-007 full SHALL be 1 when count=8; empty SHALL be 1 when count=0; both are combinational from count.
REQ-008 FSM states SHALL be IDLE, EXEC and ERROR.
REQ-009 busy SHALL be 1 only in EXEC.
REQ-010 IDLE->EXEC: when run=1, empty=0 and err=0, the FSM SHALL go to EXEC, load INST with the FIFO head, pop it and set T=0, all on the same edge.
REQ-011 In EXEC with Clr=0 and T<3, T SHALL increment by 1 each cycle.
REQ-012 In EXEC with Clr=1, the block SHALL set T=0 and increment retired, wrapping 255->0.
REQ-013 After Clr=1 in EXEC, if run=1 and empty=0 the block SHALL load and pop the next instruction on the same edge and stay in EXEC (back-to-back issue, no bubble); otherwise it SHALL go to IDLE.
REQ-014 In EXEC with T=3 and Clr=0, the block SHALL set err=1 and T=0, go to ERROR, leave retired unchanged and pop nothing.
REQ-015 ERROR SHALL be left only by reset; in ERROR, pushes still occur and no instruction is issued.
REQ-016 Clr SHALL be ignored in IDLE and ERROR.
REQ-017 Deasserting run during EXEC SHALL NOT abort the current instruction; it only blocks the next issue.
REQ-018 INST SHALL hold the last issued word in IDLE and ERROR.
REQ-019 T SHALL be 0 whenever the FSM is not in EXEC.
REQ-020 All outputs SHALL be registered, except full and empty.

Reset
REQ-021 rst=1 SHALL immediately, independent of clk, set state=IDLE, INST=10'h000, T=0, busy=0, count=0, retired=0 and err=0; full=0 and empty=1 follow from count.
REQ-022 Reset in the middle of EXEC SHALL discard the executing instruction and all queued entries.
REQ-023 wr_en, run and Clr SHALL be ignored while rst=1.

Verification
REQ-024 Scenario 1: reset, run=0, push 10'h102, 10'h213, 10'h2A0 -> count=3, busy=0, INST=10'h000, T=0.
REQ-025 Scenario 2: from scenario 1, set run=1 and pulse Clr at T=2 for each instruction -> INST takes 10'h102, 10'h213, 10'h2A0 in order with no idle cycle between them; T sequence 0,1,2,0,1,2,0,1,2; retired=3, empty=1, busy=0.
REQ-026 Scenario 3: push 9 words 10'h001..10'h009 with run=0 -> full=1 after the 8th push; count=8; after draining, 10'h009 never appears on INST.
REQ-027 Scenario 4: issue one instruction and never assert Clr -> T goes 0,1,2,3, then err=1, state ERROR, T=0, retired=0; further queued words are not issued until rst.
REQ-028 Scenario 5: assert rst asynchronously (mid-cycle) at T=1 of EXEC with count=4 -> outputs reach reset values before the next clk edge.
REQ-029 Scenario 6: with count=8, wr_en=1 on the same edge a pop occurs -> count=7 and the pushed word is dropped.
REQ-030 Scenario 6 (cont.): with count=3, push and pop on the same edge -> count stays 3 and FIFO order is preserved.
